// File: rtl/preg_pkg.sv
// Shared definitions for the preg skid stage: occupancy states and count encoding.
package preg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_TWO   = 2'd2;

    // The unused encoding maps to zero so the count can never read 3.
    function automatic logic [1:0] state_count(input state_e s);
        case (s)
            ST_ONE:  return CNT_ONE;
            ST_TWO:  return CNT_TWO;
            default: return CNT_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/preg_slot.sv
// One payload register with synchronous clear and load enable.
module preg_slot #(
    parameter int WIDTH = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // NOTE: payload registers are cleared on reset so o_data reads zero afterwards,
    // not just when o_valid is low; nonblocking assignment keeps every flop in step.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/preg_skid_stage.sv
// Valid/ready pipeline register: two-entry skid buffer (registered ready) or single entry.
module preg_skid_stage
    import preg_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter bit SKID_EN    = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_count
);

    state_e                r_state;
    state_e                w_state_nxt;
    logic                  w_in_xfer;
    logic                  w_out_xfer;
    logic                  w_main_load;
    logic                  w_skid_load;
    logic [DATA_WIDTH-1:0] w_main_d;
    logic [DATA_WIDTH-1:0] w_main_q;
    logic [DATA_WIDTH-1:0] w_skid_q;

    assign o_valid    = (r_state != ST_EMPTY);
    assign o_ready    = SKID_EN ? (r_state != ST_TWO) : (~o_valid | i_ready);
    assign w_in_xfer  = i_valid & o_ready;
    assign w_out_xfer = o_valid & i_ready;

    // NOTE: every output of this block gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_main_load = 1'b0;
        w_skid_load = 1'b0;
        if (i_flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_main_load = 1'b1;
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_main_load = 1'b1;
                    end else if (w_in_xfer && SKID_EN) begin
                        w_skid_load = 1'b1;
                        w_state_nxt = ST_TWO;
                    end else if (w_out_xfer) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_out_xfer) begin
                        w_main_load = 1'b1;
                        w_state_nxt = ST_ONE;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Draining TWO promotes the skid entry; every other main load takes fresh input.
    assign w_main_d = (r_state == ST_TWO) ? w_skid_q : i_data;

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    preg_slot #(.WIDTH(DATA_WIDTH)) u_main (
        .i_clk  (i_clk),
        .i_rst  (i_arst),
        .i_load (w_main_load),
        .i_d    (w_main_d),
        .o_q    (w_main_q)
    );

    generate
        if (SKID_EN) begin : g_skid
            preg_slot #(.WIDTH(DATA_WIDTH)) u_skid (
                .i_clk  (i_clk),
                .i_rst  (i_arst),
                .i_load (w_skid_load),
                .i_d    (i_data),
                .o_q    (w_skid_q)
            );
        end else begin : g_no_skid
            assign w_skid_q = '0;
        end
    endgenerate

    assign o_data  = w_main_q;
    assign o_count = state_count(r_state);

endmodule

// File: tb/tb_preg_skid_stage.sv
// Directed bench for preg_skid_stage: skid variant (dut) and single-entry variant (dut0).
module tb_preg_skid_stage;

    logic       clk = 1'b0;
    logic       arst;
    // skid variant
    logic       flush, valid, ready;
    logic [7:0] data;
    logic       o_ready, o_valid;
    logic [7:0] o_data;
    logic [1:0] o_count;
    // single-entry variant
    logic       n_flush, n_valid, n_ready;
    logic [7:0] n_data;
    logic       n_o_ready, n_o_valid;
    logic [7:0] n_o_data;
    logic [1:0] n_o_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    preg_skid_stage #(.DATA_WIDTH(8), .SKID_EN(1'b1)) dut (
        .i_clk(clk), .i_arst(arst), .i_flush(flush), .i_valid(valid), .o_ready(o_ready),
        .i_data(data), .o_valid(o_valid), .i_ready(ready), .o_data(o_data), .o_count(o_count)
    );

    preg_skid_stage #(.DATA_WIDTH(8), .SKID_EN(1'b0)) dut0 (
        .i_clk(clk), .i_arst(arst), .i_flush(n_flush), .i_valid(n_valid), .o_ready(n_o_ready),
        .i_data(n_data), .o_valid(n_o_valid), .i_ready(n_ready), .o_data(n_o_data),
        .o_count(n_o_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arst = 1'b1; flush = 1'b0; valid = 1'b0; ready = 1'b0; data = 8'h00;
        n_flush = 1'b0; n_valid = 1'b0; n_ready = 1'b0; n_data = 8'h00;
        tick(); tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", o_data); end
        checks++; if (o_count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", o_count); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        checks++; if (n_o_valid !== 1'b0) begin errors++; $display("FAIL reset0_valid: got %b want 0", n_o_valid); end
        checks++; if (n_o_data !== 8'h00) begin errors++; $display("FAIL reset0_data: got %h want 00", n_o_data); end
        arst = 1'b0;
    endtask

    task automatic test_single();
        valid = 1'b1; data = 8'h11; ready = 1'b1;
        tick();
        valid = 1'b0;
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", o_valid); end
        checks++; if (o_data !== 8'h11) begin errors++; $display("FAIL single_data: got %h want 11", o_data); end
        checks++; if (o_count !== 2'd1) begin errors++; $display("FAIL single_count: got %0d want 1", o_count); end
        tick();
        checks++; if (o_count !== 2'd0) begin errors++; $display("FAIL single_drain_count: got %0d want 0", o_count); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid: got %b want 0", o_valid); end
    endtask

    task automatic test_skid();
        ready = 1'b0; valid = 1'b1; data = 8'h11;
        tick();
        data = 8'h22;
        tick();
        valid = 1'b0; data = 8'h99;
        checks++; if (o_count !== 2'd2) begin errors++; $display("FAIL skid_count: got %0d want 2", o_count); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL skid_ready: got %b want 0", o_ready); end
        checks++; if (o_data !== 8'h11) begin errors++; $display("FAIL skid_data: got %h want 11", o_data); end
        tick();
        checks++; if (o_data !== 8'h11 || o_valid !== 1'b1) begin errors++; $display("FAIL skid_hold: got %h/%b want 11/1", o_data, o_valid); end
        checks++; if (o_count !== 2'd2) begin errors++; $display("FAIL skid_hold_count: got %0d want 2", o_count); end
        ready = 1'b1;
        tick();
        checks++; if (o_data !== 8'h22 || o_valid !== 1'b1) begin errors++; $display("FAIL skid_second: got %h/%b want 22/1", o_data, o_valid); end
        checks++; if (o_count !== 2'd1 || o_ready !== 1'b1) begin errors++; $display("FAIL skid_second_state: got cnt %0d rdy %b want 1/1", o_count, o_ready); end
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL skid_empty: got %b want 0", o_valid); end
    endtask

    task automatic test_stream();
        ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            valid = 1'b1; data = 8'(i);
            #1;
            checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b want 1", i, o_ready); end
            tick();
            checks++; if (o_valid !== 1'b1 || o_data !== 8'(i)) begin errors++; $display("FAIL stream_out[%0d]: got %h/%b want %h/1", i, o_data, o_valid, 8'(i)); end
        end
        valid = 1'b0;
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stream_end: got %b want 0", o_valid); end
    endtask

    task automatic test_flush();
        ready = 1'b0; valid = 1'b1; data = 8'hA1;
        tick();
        data = 8'hA2;
        tick();
        checks++; if (o_count !== 2'd2) begin errors++; $display("FAIL flush_pre_count: got %0d want 2", o_count); end
        flush = 1'b1; data = 8'h33;
        tick();
        flush = 1'b0; valid = 1'b0; ready = 1'b1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", o_valid); end
        checks++; if (o_count !== 2'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", o_count); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", o_ready); end
        checks++; if (o_data !== 8'hA1) begin errors++; $display("FAIL flush_data_kept: got %h want a1", o_data); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_idle[%0d]: got %b want 0", i, o_valid); end
        end
        valid = 1'b1; data = 8'h55;
        tick();
        valid = 1'b0;
        checks++; if (o_valid !== 1'b1 || o_data !== 8'h55) begin errors++; $display("FAIL flush_next: got %h/%b want 55/1", o_data, o_valid); end
        tick();
    endtask

    task automatic test_reset_mid();
        ready = 1'b0; valid = 1'b1; data = 8'hB1;
        tick();
        data = 8'hB2;
        tick();
        valid = 1'b0;
        checks++; if (o_count !== 2'd2) begin errors++; $display("FAIL rst_pre_count: got %0d want 2", o_count); end
        arst = 1'b1; flush = 1'b1;
        tick();
        arst = 1'b0; flush = 1'b0; ready = 1'b1;
        checks++; if (o_valid !== 1'b0 || o_data !== 8'h00) begin errors++; $display("FAIL rst_mid: got %h/%b want 00/0", o_data, o_valid); end
        checks++; if (o_count !== 2'd0 || o_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_state: got cnt %0d rdy %b want 0/1", o_count, o_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_stale[%0d]: got %b data %h want 0", i, o_valid, o_data); end
        end
    endtask

    task automatic test_noskid();
        n_valid = 1'b1; n_data = 8'h43; n_ready = 1'b0;
        #1;
        checks++; if (n_o_ready !== 1'b1) begin errors++; $display("FAIL ns_empty_ready: got %b want 1", n_o_ready); end
        tick();
        n_data = 8'h44;
        checks++; if (n_o_valid !== 1'b1 || n_o_data !== 8'h43) begin errors++; $display("FAIL ns_first: got %h/%b want 43/1", n_o_data, n_o_valid); end
        #1;
        checks++; if (n_o_ready !== 1'b0) begin errors++; $display("FAIL ns_stall_ready: got %b want 0", n_o_ready); end
        tick();
        checks++; if (n_o_data !== 8'h43 || n_o_count !== 2'd1) begin errors++; $display("FAIL ns_hold: got %h cnt %0d want 43/1", n_o_data, n_o_count); end
        n_ready = 1'b1;
        #1;
        checks++; if (n_o_ready !== 1'b1) begin errors++; $display("FAIL ns_pass_ready: got %b want 1", n_o_ready); end
        tick();
        n_valid = 1'b0;
        checks++; if (n_o_valid !== 1'b1 || n_o_data !== 8'h44) begin errors++; $display("FAIL ns_pass_data: got %h/%b want 44/1", n_o_data, n_o_valid); end
        checks++; if (n_o_count !== 2'd1) begin errors++; $display("FAIL ns_pass_count: got %0d want 1", n_o_count); end
        tick();
        checks++; if (n_o_valid !== 1'b0 || n_o_count !== 2'd0) begin errors++; $display("FAIL ns_drain: got %b cnt %0d want 0/0", n_o_valid, n_o_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_skid();
        test_stream();
        test_flush();
        test_reset_mid();
        test_noskid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/preg_skid_stage.md
PREG_SKID_STAGE -- requirements
Module: preg_skid_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 64: payload width in bits.
REQ-002 Parameter SKID_EN, default 1: 1 selects a two-entry skid stage; 0 selects a single-entry stage with combinational ready.
REQ-003 i_clk  input  1  clock; all state updates occur on its rising edge.
REQ-004 i_arst  input  1  reset, synchronous, active-high.
REQ-005 i_flush  input  1  discards all held entries.
REQ-006 i_valid  input  1  upstream payload valid.
REQ-007 o_ready  output  1  stage accepts payload this cycle.
REQ-008 i_data  input  DATA_WIDTH  upstream payload.
REQ-009 o_valid  output  1  downstream payload valid.
REQ-010 i_ready  input  1  downstream accepts payload.
REQ-011 o_data  output  DATA_WIDTH  downstream payload.
REQ-012 o_count  output  2  entries held: 0, 1 or 2.

Function
REQ-013 The stage SHALL perform an input transfer when i_valid and o_ready are both high, and an output transfer when o_valid and i_ready are both high.
REQ-014 The stage SHALL deliver payloads in strict arrival order, with no loss or duplication except by flush or reset.
REQ-015 The stage SHALL present a payload accepted into an empty stage on o_data, with o_valid high, in the next cycle: latency 1.
REQ-016 The stage SHALL hold o_data and o_valid stable while o_valid is high and i_ready is low.
REQ-017 SKID_EN=1 state machine: EMPTY, ONE (main register valid) and TWO (main and skid registers valid).
REQ-018 EMPTY: on an input transfer, the stage SHALL load main and go to ONE; otherwise it SHALL stay in EMPTY.
REQ-019 ONE, input and output transfer together: the stage SHALL load main from i_data and stay in ONE.
REQ-020 ONE, input transfer only: the stage SHALL load skid from i_data and go to TWO.
REQ-021 ONE, output transfer only: the stage SHALL go to EMPTY.
REQ-022 TWO, output transfer: the stage SHALL copy skid to main and go to ONE; otherwise it SHALL stay in TWO.
REQ-023 With SKID_EN=1, o_ready SHALL be low exactly in TWO and SHALL be a direct decode of registered state, with no combinational path from i_ready.
REQ-024 With SKID_EN=0, the stage SHALL hold at most one entry and SHALL drive o_ready = ~o_valid | i_ready.
REQ-025 o_valid SHALL be high in ONE and TWO; o_data SHALL always be the main register.
REQ-026 o_count SHALL equal 0, 1 or 2 for EMPTY, ONE or TWO, and SHALL never read 3.
REQ-027 On i_flush high, the next state SHALL be EMPTY: o_valid 0, o_count 0, o_ready 1.
REQ-028 Flush SHALL override any same-cycle transfer; the payload of a same-cycle input transfer SHALL be discarded.
REQ-029 Flush SHALL leave the data registers unchanged.
REQ-030 Reset SHALL have priority over flush, and flush SHALL have priority over transfers.

Reset
REQ-031 When i_arst is high at a rising edge, the stage SHALL enter EMPTY and clear the main and skid registers to zero.
REQ-032 Reset values: o_valid 0, o_data 0, o_count 0, o_ready 1.
REQ-033 Reset asserted mid-operation, including in TWO, SHALL discard both entries, and no held payload SHALL appear after reset deasserts.

Structure
REQ-034 The state enum typedef (EMPTY/ONE/TWO) and the count encoding constants SHALL live in the shared package preg_pkg.
REQ-035 The main and skid registers SHALL each be an instance of sub-module preg_slot: a DATA_WIDTH register with synchronous reset and load enable.
REQ-036 With SKID_EN=0, the skid slot SHALL not be instantiated.

Verification (DATA_WIDTH=8, SKID_EN=1 unless stated)
REQ-037 Reset, then i_valid=1 with i_data=0x11 for one cycle, i_ready=1 -> next cycle o_valid=1, o_data=0x11, o_count=1; following cycle o_count=0.
REQ-038 Hold i_ready=0 and send 0x11 then 0x22 -> o_count=2, o_ready=0, o_data stays 0x11; raise i_ready -> 0x11 then 0x22 out on consecutive cycles, then o_valid=0.
REQ-039 Continuous i_valid with 0x01..0x10, i_ready=1 -> one output per cycle in order, o_ready never low.
REQ-040 In TWO, assert i_flush for one cycle with i_valid=1 and i_data=0x33 -> next cycle o_valid=0, o_count=0, o_ready=1; 0x33 never appears.
REQ-041 In TWO, assert i_arst for one cycle -> o_valid=0, o_data=0x00, o_count=0; after deassertion no stale payload is emitted.
REQ-042 SKID_EN=0: o_valid=1, i_ready=1, i_valid=1 with i_data=0x44 -> o_ready=1 the same cycle, next cycle o_data=0x44; with i_ready=0 -> o_ready=0.
